// File: rtl/logic_unit_pkg.sv
// Shared opcode encodings and widths for the pipelined bitwise logic unit.
package logic_unit_pkg;
    localparam int OP_W   = 3;
    localparam int STAT_W = 16;

    localparam logic [OP_W-1:0] OP_AND   = 3'd0;
    localparam logic [OP_W-1:0] OP_OR    = 3'd1;
    localparam logic [OP_W-1:0] OP_XOR   = 3'd2;
    localparam logic [OP_W-1:0] OP_NOTB  = 3'd3;
    localparam logic [OP_W-1:0] OP_NAND  = 3'd4;
    localparam logic [OP_W-1:0] OP_NOR   = 3'd5;
    localparam logic [OP_W-1:0] OP_XNOR  = 3'd6;
    localparam logic [OP_W-1:0] OP_PASSA = 3'd7;
endpackage

// File: rtl/logic_unit_func.sv
// Combinational eight-function bitwise unit (a, b, op -> y); zero latency, no flow control.
module logic_unit_func
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic [WIDTH-1:0] y
);
    always_comb begin
        y = '0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = (a & b) ^ (a | b);
            OP_NOTB: y = ~b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XNOR: y = ~(a ^ b);
            default: y = a;    // OP_PASSA, the only remaining encoding
        endcase
    end
endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with parity/zero flags; accept-to-output latency 2, 1/cycle.
// Valid/ready backpressure, bubbles collapse; LOGIC_UNIT_PIPE_STATS_EN adds transfer/stall counters.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [OP_W-1:0]  in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_parity,
    output logic             out_zero,
`ifdef LOGIC_UNIT_PIPE_STATS_EN
    input  logic              stat_clr,
    output logic [STAT_W-1:0] stat_xfers,
    output logic [STAT_W-1:0] stat_stalls,
`endif
    output logic [OP_W-1:0]  out_op
);
    logic             s1_v;
    logic [WIDTH-1:0] s1_y;
    logic [OP_W-1:0]  s1_op;
    logic             s2_v;
    logic [WIDTH-1:0] func_y;
    logic             adv1;
    logic             adv2;
    logic             accept;

    // in_ready depends only on pipeline state, never on in_valid.
    assign adv2      = !s2_v | out_ready;
    assign adv1      = !s1_v | adv2;
    assign in_ready  = adv1;
    assign accept    = in_valid & in_ready;
    assign out_valid = s2_v;

    logic_unit_func #(.WIDTH(WIDTH)) u_func (
        .a  (in_a),
        .b  (in_b),
        .op (in_op),
        .y  (func_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v  <= 1'b0;
            s1_y  <= '0;
            s1_op <= '0;
        end else if (adv1) begin
            s1_v <= accept;
            if (accept) begin
                s1_y  <= func_y;
                s1_op <= in_op;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_v       <= 1'b0;
            out_y      <= '0;
            out_op     <= '0;
            out_parity <= 1'b0;
            out_zero   <= 1'b1;
        end else if (adv2) begin
            s2_v <= s1_v;
            if (s1_v) begin
                out_y      <= s1_y;
                out_op     <= s1_op;
                out_parity <= ^s1_y;
                out_zero   <= (s1_y == '0);
            end
        end
    end

`ifdef LOGIC_UNIT_PIPE_STATS_EN
    localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_xfers  <= '0;
            stat_stalls <= '0;
        end else if (stat_clr) begin
            stat_xfers  <= '0;
            stat_stalls <= '0;
        end else begin
            if (out_valid && out_ready && stat_xfers != STAT_MAX)
                stat_xfers <= stat_xfers + 1'b1;
            if (out_valid && !out_ready && stat_stalls != STAT_MAX)
                stat_stalls <= stat_stalls + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed-vector bench for logic_unit_pipe (WIDTH=8); stats checks compile in with LOGIC_UNIT_PIPE_STATS_EN.
module tb_logic_unit_pipe;
    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [2:0] in_op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_y;
    logic       out_parity;
    logic       out_zero;
    logic [2:0] out_op;
`ifdef LOGIC_UNIT_PIPE_STATS_EN
    logic        stat_clr;
    logic [15:0] stat_xfers;
    logic [15:0] stat_stalls;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic_unit_pipe #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_y      (out_y),
        .out_parity (out_parity),
        .out_zero   (out_zero),
`ifdef LOGIC_UNIT_PIPE_STATS_EN
        .stat_clr   (stat_clr),
        .stat_xfers (stat_xfers),
        .stat_stalls(stat_stalls),
`endif
        .out_op     (out_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Samples handshakes at the negedge, then advances to 1 time unit past the next posedge.
    task automatic tick(output bit acc, output bit xfr, output logic [7:0] y);
        @(negedge clk);
        acc = in_valid & in_ready;
        xfr = out_valid & out_ready;
        y   = out_y;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bit acc, xfr;
        logic [7:0] y;
        #3;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_vec++; if (out_y !== 8'h00) begin n_err++; $display("FAIL reset_out_y got %h want 00", out_y); end
        n_vec++; if (out_zero !== 1'b1) begin n_err++; $display("FAIL reset_out_zero got %b want 1", out_zero); end
        n_vec++; if (out_parity !== 1'b0) begin n_err++; $display("FAIL reset_out_parity got %b want 0", out_parity); end
        n_vec++; if (out_op !== 3'd0) begin n_err++; $display("FAIL reset_out_op got %0d want 0", out_op); end
        tick(acc, xfr, y);
        rst = 1'b0;
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_ops();
        logic [7:0] exp_y [8];
        bit acc, xfr;
        logic [7:0] y;
        exp_y = '{8'h88, 8'hEE, 8'h66, 8'h55, 8'h77, 8'h11, 8'h99, 8'hCC};
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in_valid = (c < 8);
            in_a = 8'hCC;
            in_b = 8'hAA;
            in_op = 3'(c);
            tick(acc, xfr, y);
            if (c < 8) begin
                n_vec++; if (acc !== 1'b1) begin n_err++; $display("FAIL ops_accept[%0d] got %b want 1", c, acc); end
            end
            if (c == 0) begin
                n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ops_latency got out_valid %b want 0", out_valid); end
            end else if (c <= 8) begin
                n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL ops_valid[%0d] got %b want 1", c - 1, out_valid); end
                n_vec++; if (out_y !== exp_y[c-1]) begin n_err++; $display("FAIL ops_y[%0d] got %h want %h", c - 1, out_y, exp_y[c-1]); end
                n_vec++; if (out_op !== 3'(c - 1)) begin n_err++; $display("FAIL ops_op[%0d] got %0d want %0d", c - 1, out_op, c - 1); end
                n_vec++; if (out_parity !== ^exp_y[c-1]) begin n_err++; $display("FAIL ops_parity[%0d] got %b want %b", c - 1, out_parity, ^exp_y[c-1]); end
            end else begin
                n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ops_drain got out_valid %b want 0", out_valid); end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_flags();
        logic [7:0] va [3];
        logic [2:0] vo [3];
        logic [7:0] ey [3];
        logic       ez [3];
        logic       ep [3];
        bit acc, xfr;
        logic [7:0] y;
        va = '{8'h0F, 8'h0F, 8'h01};
        vo = '{3'd2, 3'd1, 3'd7};
        ey = '{8'h00, 8'h0F, 8'h01};
        ez = '{1'b1, 1'b0, 1'b0};
        ep = '{1'b0, 1'b0, 1'b1};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_a = va[i]; in_b = 8'h0F; in_op = vo[i];
            tick(acc, xfr, y);
            in_valid = 1'b0;
            tick(acc, xfr, y);
            n_vec++; if (out_y !== ey[i]) begin n_err++; $display("FAIL flags_y[%0d] got %h want %h", i, out_y, ey[i]); end
            n_vec++; if (out_zero !== ez[i]) begin n_err++; $display("FAIL flags_zero[%0d] got %b want %b", i, out_zero, ez[i]); end
            n_vec++; if (out_parity !== ep[i]) begin n_err++; $display("FAIL flags_parity[%0d] got %b want %b", i, out_parity, ep[i]); end
        end
        tick(acc, xfr, y);
    endtask

    task automatic test_backpressure();
        logic [7:0] vals [4];
        logic [7:0] got [$];
        int k;
        int cyc;
        bit acc, xfr;
        logic [7:0] y;
        vals = '{8'h11, 8'h22, 8'h33, 8'h44};
        k = 0;
        out_ready = 1'b0;
        in_b = 8'h00;
        in_op = 3'd7;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1; in_a = vals[k];
            tick(acc, xfr, y);
            if (acc) k++;
        end
        #1;
        n_vec++; if (k !== 2) begin n_err++; $display("FAIL bp_accepts got %0d want 2", k); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
        n_vec++; if (out_y !== 8'h11) begin n_err++; $display("FAIL bp_hold_y got %h want 11", out_y); end
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid got %b want 1", out_valid); end
        out_ready = 1'b1;
        cyc = 0;
        while (got.size() < 4 && cyc < 30) begin
            in_valid = (k < 4);
            in_a = (k < 4) ? vals[k] : 8'h00;
            tick(acc, xfr, y);
            if (acc) k++;
            if (xfr) got.push_back(y);
            cyc++;
        end
        in_valid = 1'b0;
        n_vec++; if (got.size() !== 4) begin n_err++; $display("FAIL bp_count got %0d want 4 (timeout)", got.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < got.size()) begin
                n_vec++; if (got[i] !== vals[i]) begin n_err++; $display("FAIL bp_order[%0d] got %h want %h", i, got[i], vals[i]); end
            end
        end
        for (int i = 0; i < 3; i++) begin
            tick(acc, xfr, y);
            n_vec++; if (xfr !== 1'b0) begin n_err++; $display("FAIL bp_dup[%0d] got xfer %b want 0", i, xfr); end
        end
    endtask

    task automatic test_bubble();
        logic exp_v [3];
        bit acc, xfr;
        logic [7:0] y;
        exp_v = '{1'b1, 1'b0, 1'b1};
        out_ready = 1'b1;
        in_a = 8'h5A; in_b = 8'h00; in_op = 3'd7;
        in_valid = 1'b1;
        tick(acc, xfr, y);
        for (int i = 0; i < 3; i++) begin
            in_valid = (i == 1);
            tick(acc, xfr, y);
            n_vec++; if (out_valid !== exp_v[i]) begin n_err++; $display("FAIL bubble_valid[%0d] got %b want %b", i, out_valid, exp_v[i]); end
        end
        in_valid = 1'b0;
        tick(acc, xfr, y);
    endtask

    task automatic test_reset_mid();
        bit acc, xfr;
        logic [7:0] y;
        out_ready = 1'b0;
        in_a = 8'hF0; in_b = 8'h00; in_op = 3'd7;
        in_valid = 1'b1;
        tick(acc, xfr, y);
        tick(acc, xfr, y);
        in_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL mid_prefill got out_valid %b want 1", out_valid); end
        #2;
        rst = 1'b1;
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid got %b want 0", out_valid); end
        n_vec++; if (out_y !== 8'h00) begin n_err++; $display("FAIL mid_rst_y got %h want 00", out_y); end
        n_vec++; if (out_zero !== 1'b1) begin n_err++; $display("FAIL mid_rst_zero got %b want 1", out_zero); end
        tick(acc, xfr, y);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_in_ready got %b want 1", in_ready); end
        for (int i = 0; i < 3; i++) begin
            tick(acc, xfr, y);
            n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_stale[%0d] got out_valid %b want 0", i, out_valid); end
        end
    endtask

`ifdef LOGIC_UNIT_PIPE_STATS_EN
    task automatic test_stats();
        bit acc, xfr;
        logic [7:0] y;
        stat_clr = 1'b1;
        tick(acc, xfr, y);
        stat_clr = 1'b0;
        out_ready = 1'b0;
        in_a = 8'h01; in_b = 8'h00; in_op = 3'd7;
        in_valid = 1'b1;
        tick(acc, xfr, y);
        in_valid = 1'b0;
        tick(acc, xfr, y);
        for (int i = 0; i < 3; i++) tick(acc, xfr, y);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            tick(acc, xfr, y);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick(acc, xfr, y);
        n_vec++; if (stat_xfers !== 16'd5) begin n_err++; $display("FAIL stat_xfers got %0d want 5", stat_xfers); end
        n_vec++; if (stat_stalls !== 16'd3) begin n_err++; $display("FAIL stat_stalls got %0d want 3", stat_stalls); end
        stat_clr = 1'b1;
        tick(acc, xfr, y);
        stat_clr = 1'b0;
        n_vec++; if (stat_xfers !== 16'd0) begin n_err++; $display("FAIL stat_clr_xfers got %0d want 0", stat_xfers); end
        n_vec++; if (stat_stalls !== 16'd0) begin n_err++; $display("FAIL stat_clr_stalls got %0d want 0", stat_stalls); end
        out_ready = 1'b0;
        in_valid = 1'b1;
        tick(acc, xfr, y);
        in_valid = 1'b0;
        tick(acc, xfr, y);
        for (int i = 0; i < 65540; i++) @(posedge clk);
        #1;
        n_vec++; if (stat_stalls !== 16'hFFFF) begin n_err++; $display("FAIL stat_saturate got %h want ffff", stat_stalls); end
        out_ready = 1'b1;
        tick(acc, xfr, y);
        tick(acc, xfr, y);
    endtask
`endif

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = 8'h00;
        in_b = 8'h00;
        in_op = 3'd0;
        out_ready = 1'b1;
`ifdef LOGIC_UNIT_PIPE_STATS_EN
        stat_clr = 1'b0;
`endif
        test_reset();
        test_ops();
        test_flags();
        test_backpressure();
        test_bubble();
        test_reset_mid();
`ifdef LOGIC_UNIT_PIPE_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
